count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_arb_pkg.sv | 12 +
 rtl/count_arb_rr.sv | 20 ++
 rtl/count_arbiter.sv | 114 +++++++++++
 tb/tb_count_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/count_arb_pkg.sv
// Shared types and constants for the two-requester burst-count arbiter.
package count_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NREQ       = 2;
    localparam int CW_DEFAULT = 3;

endpackage

// File: rtl/count_arb_rr.sv
// Two-way round-robin winner select: the requester that was not last granted wins a tie.
module count_arb_rr
    import count_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin burst arbiter with a shared up-counter; each grant runs until count reaches the winner's length.
// Optional abort input is enabled by defining COUNT_ARB_ABORT_EN.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   len0,
    input  logic [CW-1:0]   len1,
`ifdef COUNT_ARB_ABORT_EN
    input  logic            abort,
`endif
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [CW-1:0]   count,
    output logic            done
);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q, len_d;
    logic            last_q, last_d;
    logic [NREQ-1:0] win;
    logic [CW-1:0]   win_len;
    logic            abort_run;

    count_arb_rr u_rr (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

`ifdef COUNT_ARB_ABORT_EN
    assign abort_run = abort && (state_q == RUN);
`else
    assign abort_run = 1'b0;
`endif

    assign win_len = win[0] ? len0 : len1;
    assign done    = (state_q == RUN) && (count_q == len_q);
    assign busy    = (state_q == RUN);
    assign gnt     = gnt_q;
    assign count   = count_q;

    // last_q holds the owner of the most recent grant; resetting it to 1 gives requester 0 priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Latched length is only meaningful while RUN, so it carries no reset
    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        len_d   = len_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = RUN;
                    gnt_d   = win;
                    count_d = '0;
                    len_d   = win_len;
                    last_d  = win[1];
                end
            end
            RUN: begin
                if (abort_run) begin
                    // Owner stays in last_q, so the other requester gets priority next
                    state_d = IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (done) begin
                    if (|req) begin
                        gnt_d   = win;
                        count_d = '0;
                        len_d   = win_len;
                        last_d  = win[1];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: bursts, back-to-back round-robin, zero length, reset and optional abort.
module tb_count_arbiter;

    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [CW-1:0] len0;
    logic [CW-1:0] len1;
`ifdef COUNT_ARB_ABORT_EN
    logic          abort;
`endif
    logic [1:0]    gnt;
    logic          busy;
    logic [CW-1:0] count;
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;

    count_arbiter #(.CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
`ifdef COUNT_ARB_ABORT_EN
        .abort (abort),
`endif
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic b,
                              input logic [CW-1:0] c, input logic d);
        chk({tag, ".gnt"},   32'(gnt),   32'(g));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        expect_out("rst", 2'b00, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        req  = 2'b00;
        len0 = '0;
        len1 = '0;
`ifdef COUNT_ARB_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        do_reset();

        // Single burst, len0=3
        req  = 2'b01;
        len0 = 3'd3;
        tick();
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("b3_c%0d", k), 2'b01, 1'b1, CW'(k), (k == 3));
            tick();
        end
        expect_out("b3_idle", 2'b00, 1'b0, 3'd0, 1'b0);

        // Back-to-back alternation with req=11 held
        do_reset();
        req  = 2'b11;
        len0 = 3'd1;
        len1 = 3'd2;
        tick(); expect_out("rr_a0", 2'b01, 1'b1, 3'd0, 1'b0);
        tick(); expect_out("rr_a1", 2'b01, 1'b1, 3'd1, 1'b1);
        tick(); expect_out("rr_b0", 2'b10, 1'b1, 3'd0, 1'b0);
        tick(); expect_out("rr_b1", 2'b10, 1'b1, 3'd1, 1'b0);
        tick(); expect_out("rr_b2", 2'b10, 1'b1, 3'd2, 1'b1);
        tick(); expect_out("rr_c0", 2'b01, 1'b1, 3'd0, 1'b0);
        req = 2'b00;
        tick(); expect_out("rr_c1", 2'b01, 1'b1, 3'd1, 1'b1);
        tick(); expect_out("rr_idle", 2'b00, 1'b0, 3'd0, 1'b0);

        // Zero-length burst on requester 1
        len1 = 3'd0;
        req  = 2'b10;
        tick(); expect_out("z_c0", 2'b10, 1'b1, 3'd0, 1'b1);
        req = 2'b00;
        tick(); expect_out("z_idle", 2'b00, 1'b0, 3'd0, 1'b0);

        // Reset in the middle of a burst
        req  = 2'b01;
        len0 = 3'd5;
        tick();
        req = 2'b00;
        tick();
        tick(); expect_out("mr_c2", 2'b01, 1'b1, 3'd2, 1'b0);
        rst = 1'b0;
        #1;
        expect_out("mr_rst", 2'b00, 1'b0, 3'd0, 1'b0);
        tick();
        rst  = 1'b1;
        req  = 2'b11;
        len0 = 3'd0;
        tick(); expect_out("mr_post", 2'b01, 1'b1, 3'd0, 1'b1);
        req = 2'b00;
        tick(); expect_out("mr_idle", 2'b00, 1'b0, 3'd0, 1'b0);

        // Length change during RUN is ignored
        req  = 2'b01;
        len0 = 3'd5;
        tick();
        req = 2'b00;
        tick();
        tick(); expect_out("lc_c2", 2'b01, 1'b1, 3'd2, 1'b0);
        len0 = 3'd1;
        for (int k = 3; k < 6; k++) begin
            tick();
            expect_out($sformatf("lc_c%0d", k), 2'b01, 1'b1, CW'(k), (k == 5));
        end
        tick(); expect_out("lc_idle", 2'b00, 1'b0, 3'd0, 1'b0);

`ifdef COUNT_ARB_ABORT_EN
        // Abort mid-burst hands priority to requester 1
        req  = 2'b01;
        len0 = 3'd7;
        tick();
        req = 2'b00;
        repeat (4) tick();
        expect_out("ab_c4", 2'b01, 1'b1, 3'd4, 1'b0);
        abort = 1'b1;
        req   = 2'b11;
        tick(); expect_out("ab_idle", 2'b00, 1'b0, 3'd0, 1'b0);
        abort = 1'b0;
        tick(); expect_out("ab_regrant", 2'b10, 1'b1, 3'd0, 1'b1);
        req = 2'b00;
        tick(); expect_out("ab_end", 2'b00, 1'b0, 3'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
